// File: rtl/onehot_seq_pkg.sv
// Shared constants for the one-hot sequencer: mode encodings and parameter
// legality limits used at elaboration time.
package onehot_seq_pkg;

    localparam logic [1:0] MODE_DIRECT    = 2'b00;
    localparam logic [1:0] MODE_SCAN_UP   = 2'b01;
    localparam logic [1:0] MODE_SCAN_DOWN = 2'b10;
    localparam logic [1:0] MODE_HOLD      = 2'b11;

    localparam int MIN_N_OUT = 2;
    localparam int MAX_SEL_W = 30;

    function automatic bit params_legal(input int sel_w, input int n_out);
        return (sel_w >= 1) && (sel_w <= MAX_SEL_W) &&
               (n_out >= MIN_N_OUT) && (n_out <= (1 << sel_w));
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational SEL_W -> N_OUT one-hot decoder; out-of-range indices decode
// to all-zero with valid low.
module onehot_dec #(
    parameter int SEL_W = 4,
    parameter int N_OUT = 8
) (
    input  logic [SEL_W-1:0] idx,
    output logic [N_OUT-1:0] onehot,
    output logic             valid
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N_OUT; i++) begin
            onehot[i] = (idx == SEL_W'(i));
        end
    end

    assign valid = {1'b0, idx} < (SEL_W + 1)'(N_OUT);

endmodule

// File: rtl/onehot_sequencer.sv
// Registered one-hot select sequencer: direct decode, dwell-timed scan up/down
// with wrap pulse, and hold. All outputs are registered.
module onehot_sequencer
    import onehot_seq_pkg::*;
#(
    parameter int SEL_W   = 4,
    parameter int N_OUT   = 8,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [N_OUT-1:0]   out,
    output logic [SEL_W-1:0]   index,
    output logic               wrap,
    output logic               err
);

    if (!params_legal(SEL_W, N_OUT)) begin : g_illegal_params
        $error("onehot_sequencer: illegal SEL_W/N_OUT combination");
    end

    localparam logic [SEL_W-1:0] LAST_INDEX = SEL_W'(N_OUT - 1);

    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_eff;
    logic [DWELL_W-1:0] cnt_next;
    logic [1:0]         prev_mode;
    logic               mode_change;
    logic               dwell_done;
    logic               index_in_range;
    logic [SEL_W-1:0]   index_next;
    logic               wrap_next;
    logic               err_next;
    logic               load_out;
    logic [N_OUT-1:0]   dec_onehot;
    logic               dec_valid;

    // A mode change restarts the dwell count, and the new mode acts on it at once.
    assign mode_change    = (mode != prev_mode);
    assign cnt_eff        = mode_change ? '0 : cnt;
    assign dwell_done     = (cnt_eff >= dwell);
    assign index_in_range = {1'b0, index} < (SEL_W + 1)'(N_OUT);

    always_comb begin
        index_next = index;
        cnt_next   = cnt;
        err_next   = err;
        wrap_next  = 1'b0;
        load_out   = 1'b0;
        case (mode)
            MODE_DIRECT: begin
                index_next = sel;
                cnt_next   = '0;
                load_out   = 1'b1;
            end
            MODE_SCAN_UP, MODE_SCAN_DOWN: begin
                if (dwell_done) begin
                    cnt_next = '0;
                    load_out = 1'b1;
                    if (!index_in_range) begin
                        // Recover from a leftover DIRECT error without a wrap pulse.
                        index_next = (mode == MODE_SCAN_UP) ? '0 : LAST_INDEX;
                        err_next   = 1'b0;
                    end else if (mode == MODE_SCAN_UP) begin
                        if (index == LAST_INDEX) begin
                            index_next = '0;
                            wrap_next  = 1'b1;
                        end else begin
                            index_next = index + 1'b1;
                        end
                    end else begin
                        if (index == '0) begin
                            index_next = LAST_INDEX;
                            wrap_next  = 1'b1;
                        end else begin
                            index_next = index - 1'b1;
                        end
                    end
                end else begin
                    cnt_next = cnt_eff + 1'b1;
                end
            end
            default: begin
                cnt_next = cnt_eff;
            end
        endcase
    end

    onehot_dec #(
        .SEL_W (SEL_W),
        .N_OUT (N_OUT)
    ) u_dec (
        .idx    (index_next),
        .onehot (dec_onehot),
        .valid  (dec_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            index     <= '0;
            wrap      <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
            prev_mode <= MODE_HOLD;
        end else if (en) begin
            prev_mode <= mode;
            cnt       <= cnt_next;
            index     <= index_next;
            wrap      <= wrap_next;
            err       <= (mode == MODE_DIRECT) ? !dec_valid : err_next;
            if (load_out) begin
                out <= dec_onehot;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: doc/onehot_sequencer.md
Name: onehot_sequencer

Overview:
Parametrised, registered successor to the 3-to-8 one-hot decoder used in the RNG datapath. It drives N_OUT one-hot select lines and has four modes: direct decode of an index, auto-scan up, auto-scan down, and hold. Each scan position is held for a programmable dwell time. The block sits between the RNG control logic and the output/tap-select stage.

Parameters:
SEL_W, 4, width of the index input and index output
N_OUT, 8, number of one-hot output lines; legal range 2 <= N_OUT <= 2**SEL_W
DWELL_W, 8, width of the dwell-count input

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
en  input  1  clock enable; when low, all state holds
mode  input  2  00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD
sel  input  SEL_W  index to decode in DIRECT mode
dwell  input  DWELL_W  cycles per scan position, minus 1
out  output  N_OUT  registered one-hot select
index  output  SEL_W  registered current index
wrap  output  1  one-cycle pulse when a scan wraps
err  output  1  sticky flag: last DIRECT index was out of range

Behaviour:
- One clock domain. Reset is synchronous and active-high. rst has priority over en.
- Reset values:
  - out = 0
  - index = 0
  - wrap = 0
  - err = 0
  - internal dwell counter cnt = 0
  - internal prev_mode = HOLD
- en=0: out, index, err, cnt and prev_mode hold; wrap = 0.
- Mode change: if mode != prev_mode on an enabled cycle, cnt <= 0 and prev_mode <= mode. The new mode's action is applied in that same cycle.
- DIRECT (latency 1 cycle):
  - index <= sel; cnt <= 0.
  - If sel < N_OUT: out <= 1 << sel; err <= 0.
  - Otherwise: out <= 0 (all zero); err <= 1.
- SCAN_UP, per enabled cycle:
  - If cnt >= dwell (a live compare, so lowering dwell mid-count ends the dwell immediately): cnt <= 0 and the index steps.
  - Otherwise: cnt <= cnt + 1, and index/out hold.
  - Step rule: if index == N_OUT-1, index <= 0 and wrap = 1 for that cycle. Otherwise index <= index + 1.
  - If index >= N_OUT (left over from a DIRECT error), the step goes to 0 with no wrap pulse, and err <= 0.
  - out <= one-hot of the new index, in the same cycle as the index update.
- SCAN_DOWN: same as SCAN_UP, except the step is index - 1.
  - From 0, the step goes to N_OUT-1 with wrap = 1.
  - From an out-of-range index, the step goes to N_OUT-1 with no wrap; err <= 0.
- Scan timing: with dwell = D, each position is held D+1 enabled cycles. dwell = 0 steps every cycle.
- Scan modes never produce out = 0 after their first step.
- HOLD: out, index, err and cnt hold; wrap = 0.
- Invariants:
  - out is either zero or exactly one-hot.
  - When out is nonzero, out == 1 << index.
- Reset mid-scan: state returns to reset values on the next edge. The first enabled cycle after reset counts as a mode change if mode != HOLD.

Decomposition:
- Shared package onehot_seq_pkg:
  - mode localparams: MODE_DIRECT = 2'b00, MODE_SCAN_UP = 2'b01, MODE_SCAN_DOWN = 2'b10, MODE_HOLD = 2'b11
  - parameter-legality check constants
- One sub-module, onehot_dec: a combinational, parametrised SEL_W -> N_OUT decoder with a valid output. It replaces the fixed 3-to-8 decoder.
- The sequencer registers onehot_dec's output, which avoids duplicating the decode logic in each mode.

Test Plan:
- Reset then DIRECT: rst=1 for 2 cycles, then mode=00, sel=5, en=1 -> one cycle later out = 8'b0010_0000, index = 5, err = 0.
- DIRECT out of range: sel=9 (N_OUT=8) -> out = 0, index = 9, err = 1. Then switch to SCAN_UP with dwell=0 -> next cycle index = 0, out = 8'h01, err = 0, wrap = 0.
- SCAN_UP, dwell=2, starting from index 6:
  - index 6 is held 3 cycles, then index 7 for 3 cycles, then index 0 with wrap = 1 for exactly that one cycle.
  - out stays one-hot throughout.
- SCAN_DOWN, dwell=0, from index 1 -> index sequence 0, 7 (wrap = 1), 6, 5. Toggling en=0 for 4 cycles mid-sequence freezes index and cnt, with wrap = 0.
- Mode change and dwell change: scanning with dwell=5, switch to HOLD at cnt=3 -> out, index and cnt frozen. Back to SCAN_UP -> cnt restarts at 0. Lowering dwell to 1 while cnt=3 -> step on the next cycle.
- Reset mid-scan and parameter sweep: rst asserted with index=4 -> all outputs 0 on the next edge. Repeat the SCAN_UP wrap test with SEL_W=3, N_OUT=5 and SEL_W=5, N_OUT=32 -> wrap occurs at index N_OUT-1.
